xor_and_gate: RTL and testbench
===============================

XOR_AND_GATE -- requirements
Module: xor_and_gate

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of a, b, c and y; legal range 1 to 32.
REQ-002 Parameter: CNT_W, default 8, bit width of hit_cnt; legal range 2 to 16.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  XOR operand 0.
REQ-006 Port: b  input  WIDTH  XOR operand 1.
REQ-007 Port: c  input  WIDTH  AND mask.
REQ-008 Port: y  output  WIDTH  result, f = (a XOR b) AND c, bitwise per bit.
REQ-009 Port: y_any  output  1  OR-reduction of y.
REQ-010 Port: hit_cnt  output  CNT_W  saturating count of clock edges on which f was nonzero.

Function
REQ-011 Function: internal combinational value f SHALL equal (a ^ b) & c, independently per bit.
REQ-012 Function: 1-bit truth table (abc -> f): 000->0, 001->0, 010->0, 011->1, 100->0, 101->1, 110->0, 111->0.
REQ-013 Function: y SHALL present f with the latency defined in Configuration.
REQ-014 Function: y_any SHALL be combinationally derived from y (same timing as y), with no added latency.
REQ-015 Function: on each rising edge with rst_n=1 and f != 0, hit_cnt SHALL increment by 1.
REQ-016 Function: hit_cnt SHALL saturate at 2^CNT_W-1 and never wrap; it holds when f == 0.
REQ-017 Function: when rst_n=0 and f != 0 at the same edge, reset SHALL win and hit_cnt becomes 0.
REQ-018 Function: unknown or X inputs are out of scope; no X-propagation handling is required.

Reset
REQ-019 Reset: rst_n=0 at a rising edge SHALL clear hit_cnt to 0 and, when registered, clear y to 0 (so y_any=0).
REQ-020 Reset: reset SHALL take effect only at a clock edge; asserting rst_n asynchronously between edges SHALL change no output.
REQ-021 Reset: releasing reset SHALL resume normal operation at the first rising edge with rst_n=1.
REQ-022 Reset: asserting reset mid-stream SHALL discard any in-flight registered result.

Configuration
REQ-023 Configuration: macro XOR_AND_GATE_REG_OUT_EN controls output registration.
REQ-024 Configuration: with the macro defined, y SHALL be registered, with 1-cycle latency (y at edge N+1 = f sampled at edge N), and reset to 0.
REQ-025 Configuration: with the macro undefined, y SHALL equal f combinationally with zero latency and be unaffected by rst_n.
REQ-026 Configuration: hit_cnt behaviour SHALL be identical in both configurations.

Verification
REQ-027 Verification: WIDTH=1, all 8 abc combinations applied in binary order, one per cycle -> y follows the REQ-012 table (one cycle delayed when registered); hit_cnt ends at 2.
REQ-028 Verification: WIDTH=4, a=4'b1100, b=4'b1010, c=4'b0111 -> y=4'b0110, y_any=1.
REQ-029 Verification: CNT_W=2, hold a=1, b=0, c=1 for 6 cycles -> hit_cnt goes 1, 2, 3, 3, 3, 3.
REQ-030 Verification: rst_n=0 for one edge while f=1 and hit_cnt=2 -> hit_cnt=0 and, when registered, y=0 after that edge; counting resumes on the next edge.
REQ-031 Verification: rst_n pulsed low between edges only -> no output change.
REQ-032 Verification: run REQ-027 with and without XOR_AND_GATE_REG_OUT_EN -> same y sequence, offset by exactly one cycle.

Source files
------------

// File: rtl/xor_and_gate.sv
// xor_and_gate: per-bit f = (a ^ b) & c, with OR-reduced flag and a
// saturating count of clock edges on which f was nonzero.
// Optional feature macro: XOR_AND_GATE_REG_OUT_EN
//   defined   -> y registered (1-cycle latency, cleared by rst_n)
//   undefined -> y is f combinationally, independent of rst_n
// hit_cnt behaves identically in both builds.

// One bit slice of the XOR/AND function.
module xor_and_gate_lane (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);
  assign f = (a ^ b) & c;
endmodule

module xor_and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] f;
  logic [CNT_W-1:0] hit_cnt_d, hit_cnt_q;

  // Bit slices are independent; one lane instance per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    xor_and_gate_lane u_lane (
      .a (a[i]),
      .b (b[i]),
      .c (c[i]),
      .f (f[i])
    );
  end

  // Count edges with a nonzero result; stick at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if ((|f) && (hit_cnt_q != CNT_MAX))
      hit_cnt_d = hit_cnt_q + CNT_ONE;
  end

  // Counter state; synchronous reset dominates a simultaneous hit.
  always_ff @(posedge clk) begin
    if (!rst_n) hit_cnt_q <= '0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;

`ifdef XOR_AND_GATE_REG_OUT_EN
  logic [WIDTH-1:0] y_d, y_q;

  // Next registered result is simply this cycle's f.
  always_comb begin
    y_d = f;
  end

  // Output register; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y_d;
  end

  assign y = y_q;
`else
  assign y = f;
`endif

  // Flag follows y with no extra stage.
  assign y_any = |y;

endmodule

// File: tb/tb_xor_and_gate.sv
// Scoreboard bench for xor_and_gate (WIDTH=4, CNT_W=3). A driver applies
// directed and random vectors one per cycle and pushes the expected
// outputs from a truth-table reference model; a monitor pops and compares
// on every falling edge. Works with or without XOR_AND_GATE_REG_OUT_EN.
module tb_xor_and_gate;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0]  y;
    logic          y_any;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  a = '0, b = '0, c = '0;
  logic [W-1:0]  y;
  logic          y_any;
  logic [CW-1:0] hit_cnt;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // Reference model state: values after the most recent rising edge.
  int           m_cnt  = 0;
  logic [W-1:0] m_yreg = '0;

  xor_and_gate #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c       (c),
    .y       (y),
    .y_any   (y_any),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  // Truth-table lookup per bit, indexed by {a,b,c}.
  function automatic logic [W-1:0] ref_f(logic [W-1:0] ra, logic [W-1:0] rb,
                                         logic [W-1:0] rc);
    bit tt[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = tt[{ra[i], rb[i], rc[i]}];
    return r;
  endfunction

  // Advance one cycle: account for the edge just taken (using the inputs
  // held across it), then apply new inputs and queue the expected outputs.
  task automatic step(input logic [W-1:0] na, input logic [W-1:0] nb,
                      input logic [W-1:0] nc, input logic nrst);
    logic [W-1:0] fv;
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_cnt  = 0;
      m_yreg = '0;
    end else begin
      fv = ref_f(a, b, c);
      if (fv != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_yreg = fv;
    end
    a = na; b = nb; c = nc; rst_n = nrst;
`ifdef XOR_AND_GATE_REG_OUT_EN
    e.y = m_yreg;
`else
    e.y = ref_f(na, nb, nc);
`endif
    e.y_any = (e.y != 0);
    e.cnt   = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Stimulus.
  initial begin
    logic [2:0] abc;
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b1);
    // Full 1-bit truth table on bit 0, binary order.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      step(W'(abc[2]), W'(abc[1]), W'(abc[0]), 1'b1);
    end
    // Multi-bit vector.
    step(4'b1100, 4'b1010, 4'b0111, 1'b1);
    step(4'b1100, 4'b1010, 4'b0111, 1'b1);
    step('0, '0, '0, 1'b1);
    // Saturation: hold a nonzero result well past the count limit.
    for (int i = 0; i < CMAX + 3; i++) step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    // Reset with f nonzero, then resume counting.
    step('0, '0, '0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    step(4'b0001, 4'b0000, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    step(4'b0001, 4'b0000, 4'b0001, 1'b1);
    // Glitch rst_n between edges only; nothing may change.
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 4'b0011, 4'b1111, 1'b1);
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
    // Random traffic with occasional reset and masked-off cycles.
    for (int i = 0; i < 300; i++) begin
      step(W'($urandom), W'($urandom),
           ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
           ($urandom_range(0, 19) != 0));
    end
    @(posedge clk);
    #1 done = 1'b1;
  end

  // Monitor: compare queued expectations on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (y !== e.y) begin
        bad++;
        $display("FAIL y t=%0t got=%b want=%b", $time, y, e.y);
      end
      total++;
      if (y_any !== e.y_any) begin
        bad++;
        $display("FAIL y_any t=%0t got=%b want=%b", $time, y_any, e.y_any);
      end
      total++;
      if (hit_cnt !== e.cnt) begin
        bad++;
        $display("FAIL hit_cnt t=%0t got=%0d want=%0d", $time, hit_cnt, e.cnt);
      end
    end else if (done) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
